// File: rtl/eight_twenty_gearbox_if.sv
// Purpose : handshake/bus bundle for eight_twenty_gearbox.
//           The pack channel takes 8-word beats and delivers 20-word beats.
//           The unpack channel takes 20-word beats and delivers 8-word beats.
// Ports   : pack_din/_valid/_ready     8-word input beat and its handshake
//           pack_dout/_valid/_ready    20-word output beat and its handshake
//           unpack_din/_valid/_ready   20-word input beat and its handshake
//           unpack_dout/_valid/_ready  8-word output beat and its handshake
// Modports: slave  - the gearbox side
//           master - the environment side (sources din, sinks dout)
interface eight_twenty_gearbox_if #(
    parameter int unsigned WORD_LEN = 16
);
    logic [8*WORD_LEN-1:0]  pack_din;
    logic                   pack_din_valid;
    logic                   pack_din_ready;
    logic [20*WORD_LEN-1:0] pack_dout;
    logic                   pack_dout_valid;
    logic                   pack_dout_ready;

    logic [20*WORD_LEN-1:0] unpack_din;
    logic                   unpack_din_valid;
    logic                   unpack_din_ready;
    logic [8*WORD_LEN-1:0]  unpack_dout;
    logic                   unpack_dout_valid;
    logic                   unpack_dout_ready;

    modport slave (
        input  pack_din, pack_din_valid, pack_dout_ready,
        input  unpack_din, unpack_din_valid, unpack_dout_ready,
        output pack_din_ready, pack_dout, pack_dout_valid,
        output unpack_din_ready, unpack_dout, unpack_dout_valid
    );

    modport master (
        output pack_din, pack_din_valid, pack_dout_ready,
        output unpack_din, unpack_din_valid, unpack_dout_ready,
        input  pack_din_ready, pack_dout, pack_dout_valid,
        input  unpack_din_ready, unpack_dout, unpack_dout_valid
    );
endinterface

// File: rtl/eight_twenty_gearbox.sv
// Purpose : dual-direction 8 <-> 20 word gearbox. Two independent channels,
//           each a 24-word shift buffer with a fill count; word 0 (LSBs) is
//           the oldest word and the word stream is preserved exactly.
// Ports   : clk         rising-edge clock
//           arst        asynchronous active-high reset (counts and buffers to 0)
//           bus         eight_twenty_gearbox_if.slave (pack + unpack handshakes)
//           pack_fill   [4:0] pack fill count   (only with EIGHT_TWENTY_GEARBOX_FILL_EN)
//           unpack_fill [4:0] unpack fill count (only with EIGHT_TWENTY_GEARBOX_FILL_EN)
// Options : define EIGHT_TWENTY_GEARBOX_FILL_EN to expose the fill counts.

// One gearbox direction: pop removes OUT_WORDS from the bottom, push appends
// IN_WORDS at the (post-pop) fill level. Words above the fill level stay zero.
module eight_twenty_gearbox_lane #(
    parameter int unsigned WORD_LEN  = 16,
    parameter int unsigned IN_WORDS  = 8,
    parameter int unsigned OUT_WORDS = 20,
    parameter int unsigned DEPTH     = 24,
    parameter int unsigned CNT_W     = 5
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [IN_WORDS*WORD_LEN-1:0]  din_i,
    output logic [CNT_W-1:0]              cnt_o,
    output logic [OUT_WORDS*WORD_LEN-1:0] dout_o
);
    localparam int unsigned DW = DEPTH * WORD_LEN;
    localparam int unsigned IW = IN_WORDS * WORD_LEN;
    localparam int unsigned OW = OUT_WORDS * WORD_LEN;

    logic [DW-1:0]    buf_q, buf_d;
    logic [DW-1:0]    shifted;
    logic [DW-1:0]    ins_mask;
    logic [DW-1:0]    ins_data;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] base;

    // Next buffer/count: optional pop-shift first, then append at the new level.
    always_comb begin
        shifted = buf_q;
        base    = cnt_q;
        if (pop_i) begin
            shifted = buf_q >> OW;
            base    = cnt_q - CNT_W'(OUT_WORDS);
        end
        ins_mask = DW'({IW{1'b1}}) << (WORD_LEN * 32'(base));
        ins_data = DW'(din_i) << (WORD_LEN * 32'(base));
        buf_d    = shifted;
        cnt_d    = base;
        if (push_i) begin
            buf_d = (shifted & ~ins_mask) | ins_data;
            cnt_d = base + CNT_W'(IN_WORDS);
        end
    end

    // Buffer and fill count registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign dout_o = buf_q[OW-1:0];
endmodule

module eight_twenty_gearbox #(
    parameter int unsigned WORD_LEN = 16
) (
    input  logic                   clk,
    input  logic                   arst,
    eight_twenty_gearbox_if.slave  bus
`ifdef EIGHT_TWENTY_GEARBOX_FILL_EN
    ,
    output logic [4:0]             pack_fill,
    output logic [4:0]             unpack_fill
`endif
);
    localparam int unsigned NARROW = 8;
    localparam int unsigned WIDE   = 20;
    localparam int unsigned DEPTH  = 24;
    localparam int unsigned CNT_W  = 5;

    logic [CNT_W-1:0] pc;
    logic [CNT_W-1:0] uc;
    logic             pack_rdy_c, pack_vld_c, pack_push_c, pack_pop_c;
    logic             unpack_rdy_c, unpack_vld_c, unpack_push_c, unpack_pop_c;

    // Ready/valid depend on the fill count only, never on the partner handshake.
    assign pack_rdy_c    = (pc < CNT_W'(WIDE));
    assign pack_vld_c    = (pc >= CNT_W'(WIDE));
    assign pack_push_c   = bus.pack_din_valid & pack_rdy_c;
    assign pack_pop_c    = pack_vld_c & bus.pack_dout_ready;

    assign unpack_rdy_c  = (uc < CNT_W'(NARROW));
    assign unpack_vld_c  = (uc >= CNT_W'(NARROW));
    assign unpack_push_c = bus.unpack_din_valid & unpack_rdy_c;
    assign unpack_pop_c  = unpack_vld_c & bus.unpack_dout_ready;

    assign bus.pack_din_ready    = pack_rdy_c;
    assign bus.pack_dout_valid   = pack_vld_c;
    assign bus.unpack_din_ready  = unpack_rdy_c;
    assign bus.unpack_dout_valid = unpack_vld_c;

    // 8 words in, 20 words out.
    eight_twenty_gearbox_lane #(
        .WORD_LEN (WORD_LEN),
        .IN_WORDS (NARROW),
        .OUT_WORDS(WIDE),
        .DEPTH    (DEPTH),
        .CNT_W    (CNT_W)
    ) u_pack (
        .clk   (clk),
        .arst  (arst),
        .push_i(pack_push_c),
        .pop_i (pack_pop_c),
        .din_i (bus.pack_din),
        .cnt_o (pc),
        .dout_o(bus.pack_dout)
    );

    // 20 words in, 8 words out.
    eight_twenty_gearbox_lane #(
        .WORD_LEN (WORD_LEN),
        .IN_WORDS (WIDE),
        .OUT_WORDS(NARROW),
        .DEPTH    (DEPTH),
        .CNT_W    (CNT_W)
    ) u_unpack (
        .clk   (clk),
        .arst  (arst),
        .push_i(unpack_push_c),
        .pop_i (unpack_pop_c),
        .din_i (bus.unpack_din),
        .cnt_o (uc),
        .dout_o(bus.unpack_dout)
    );

`ifdef EIGHT_TWENTY_GEARBOX_FILL_EN
    // Fill counts come straight from the count registers.
    assign pack_fill   = pc;
    assign unpack_fill = uc;
`endif
endmodule

// File: tb/tb_eight_twenty_gearbox.sv
// Self-checking bench for eight_twenty_gearbox: queue-based word-stream model
// compared against the DUT every cycle, plus literal expectations per scenario.
module tb_eight_twenty_gearbox;
    localparam int unsigned W = 16;
    typedef logic [20*W-1:0] wide_t;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    eight_twenty_gearbox_if #(.WORD_LEN(W)) bus ();

    logic [8*W-1:0]  p_din_d;
    logic            p_v_d, p_r_d;
    logic [20*W-1:0] u_din_d;
    logic            u_v_d, u_r_d;
    logic            loop_mode, gate;

    assign bus.pack_din          = p_din_d;
    assign bus.pack_din_valid    = p_v_d;
    assign bus.pack_dout_ready   = loop_mode ? (bus.unpack_din_ready & gate) : p_r_d;
    assign bus.unpack_din        = loop_mode ? bus.pack_dout : u_din_d;
    assign bus.unpack_din_valid  = loop_mode ? (bus.pack_dout_valid & gate) : u_v_d;
    assign bus.unpack_dout_ready = u_r_d;

`ifdef EIGHT_TWENTY_GEARBOX_FILL_EN
    logic [4:0] pack_fill, unpack_fill;
`endif

    eight_twenty_gearbox #(.WORD_LEN(W)) dut (
        .clk (clk),
        .arst(arst),
        .bus (bus)
`ifdef EIGHT_TWENTY_GEARBOX_FILL_EN
        ,
        .pack_fill  (pack_fill),
        .unpack_fill(unpack_fill)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input wide_t act, input wide_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: each channel is just a queue of words.
    logic [W-1:0] pq[$];
    logic [W-1:0] uq[$];
    logic [W-1:0] p_log[$];
    logic [W-1:0] u_log[$];
    bit m_ppush, m_ppop, m_upush, m_upop;

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            pq.delete();
            uq.delete();
        end else begin
            m_ppush = p_v_d && (pq.size() < 20);
            m_ppop  = (pq.size() >= 20) && (loop_mode ? ((uq.size() < 8) && gate) : p_r_d);
            m_upop  = (uq.size() >= 8) && u_r_d;
            m_upush = loop_mode ? m_ppop : (u_v_d && (uq.size() < 8));
            if (m_upop)  for (int i = 0; i < 8; i++)  void'(uq.pop_front());
            if (m_upush) for (int i = 0; i < 20; i++) uq.push_back(loop_mode ? pq[i] : u_din_d[i*W +: W]);
            if (m_ppop)  for (int i = 0; i < 20; i++) void'(pq.pop_front());
            if (m_ppush) for (int i = 0; i < 8; i++)  pq.push_back(p_din_d[i*W +: W]);
        end
    end

    function automatic wide_t q_beat(input logic [W-1:0] q[$], input int n);
        wide_t r;
        r = '0;
        for (int i = 0; i < n; i++) r[i*W +: W] = q[i];
        return r;
    endfunction

    function automatic int seq_err(input logic [W-1:0] q[$]);
        int e;
        e = 0;
        for (int i = 0; i < q.size(); i++) if (q[i] !== W'(i + 1)) e++;
        return e;
    endfunction

    // Per-cycle comparison against the model plus logging of DUT transfers.
    always @(negedge clk) begin
        if (!arst) begin
            chk("pack_din_ready",    wide_t'(bus.pack_din_ready),    wide_t'(pq.size() < 20));
            chk("pack_dout_valid",   wide_t'(bus.pack_dout_valid),   wide_t'(pq.size() >= 20));
            chk("unpack_din_ready",  wide_t'(bus.unpack_din_ready),  wide_t'(uq.size() < 8));
            chk("unpack_dout_valid", wide_t'(bus.unpack_dout_valid), wide_t'(uq.size() >= 8));
            if (pq.size() >= 20) chk("pack_dout", wide_t'(bus.pack_dout), q_beat(pq, 20));
            if (uq.size() >= 8)  chk("unpack_dout", wide_t'(bus.unpack_dout), q_beat(uq, 8));
`ifdef EIGHT_TWENTY_GEARBOX_FILL_EN
            chk("pack_fill",   wide_t'(pack_fill),   wide_t'(pq.size()));
            chk("unpack_fill", wide_t'(unpack_fill), wide_t'(uq.size()));
`endif
            if (bus.pack_dout_valid && bus.pack_dout_ready)
                for (int i = 0; i < 20; i++) p_log.push_back(bus.pack_dout[i*W +: W]);
            if (bus.unpack_dout_valid && bus.unpack_dout_ready)
                for (int i = 0; i < 8; i++) u_log.push_back(bus.unpack_dout[i*W +: W]);
        end
    end

    function automatic logic [8*W-1:0] beat8(input int first);
        logic [8*W-1:0] r;
        for (int i = 0; i < 8; i++) r[i*W +: W] = W'(first + i);
        return r;
    endfunction

    function automatic logic [20*W-1:0] beat20(input int first);
        logic [20*W-1:0] r;
        for (int i = 0; i < 20; i++) r[i*W +: W] = W'(first + i);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        p_din_d = '0; p_v_d = 1'b0; p_r_d = 1'b0;
        u_din_d = '0; u_v_d = 1'b0; u_r_d = 1'b0;
        loop_mode = 1'b0; gate = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        p_log.delete();
        u_log.delete();
        arst = 1'b0;
        step();
    endtask

    task automatic push_pack(input int first);
        bit acc;
        bit done;
        done = 1'b0;
        p_din_d = beat8(first);
        p_v_d   = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            acc = (pq.size() < 20);
            step();
            done = acc;
        end
        p_v_d = 1'b0;
        if (!done) chk("pack_push_timeout", 0, 1);
    endtask

    task automatic push_unpack(input int first);
        bit acc;
        bit done;
        done = 1'b0;
        u_din_d = beat20(first);
        u_v_d   = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            acc = (uq.size() < 8);
            step();
            done = acc;
        end
        u_v_d = 1'b0;
        if (!done) chk("unpack_push_timeout", 0, 1);
    endtask

    task automatic run_pack_basic(input string tag);
        p_r_d = 1'b1;
        for (int b = 0; b < 5; b++) push_pack(1 + 8*b);
        repeat (4) step();
        chk({tag, "_words"}, wide_t'(p_log.size()), 40);
        chk({tag, "_order"}, wide_t'(seq_err(p_log)), 0);
        chk({tag, "_w19"},   wide_t'(p_log[19]), 20);
        chk({tag, "_w20"},   wide_t'(p_log[20]), 21);
        chk({tag, "_ready"}, wide_t'(bus.pack_din_ready), 1);
        chk({tag, "_valid"}, wide_t'(bus.pack_dout_valid), 0);
    endtask

    int next_word;
    bit acc_l;

    initial begin
        p_din_d = '0; p_v_d = 1'b0; p_r_d = 1'b0;
        u_din_d = '0; u_v_d = 1'b0; u_r_d = 1'b0;
        loop_mode = 1'b0; gate = 1'b0;
        #1;
        chk("rst_pack_valid",    wide_t'(bus.pack_dout_valid), 0);
        chk("rst_unpack_valid",  wide_t'(bus.unpack_dout_valid), 0);
        chk("rst_pack_ready",    wide_t'(bus.pack_din_ready), 1);
        chk("rst_unpack_ready",  wide_t'(bus.unpack_din_ready), 1);

        // Pack from reset, downstream always ready.
        do_reset();
        run_pack_basic("t1");

        // Pack with backpressure.
        do_reset();
        p_r_d = 1'b0;
        for (int b = 0; b < 3; b++) push_pack(1 + 8*b);
        chk("bp_valid", wide_t'(bus.pack_dout_valid), 1);
        chk("bp_ready", wide_t'(bus.pack_din_ready), 0);
        p_din_d = beat8(25);
        p_v_d   = 1'b1;
        repeat (4) step();
        chk("bp_refused", wide_t'(bus.pack_din_ready), 0);
        chk("bp_hold_w0", wide_t'(bus.pack_dout[0 +: W]), 1);
        chk("bp_hold_w19", wide_t'(bus.pack_dout[19*W +: W]), 20);
        chk("bp_no_pop", wide_t'(p_log.size()), 0);
        p_r_d = 1'b1;
        push_pack(25);
        push_pack(33);
        repeat (4) step();
        chk("bp_words", wide_t'(p_log.size()), 40);
        chk("bp_order", wide_t'(seq_err(p_log)), 0);

        // Unpack from reset.
        do_reset();
        u_r_d = 1'b1;
        push_unpack(1);
        for (int t = 0; t < 20 && !bus.unpack_din_ready; t++) step();
        chk("up_ready_back", wide_t'(bus.unpack_din_ready), 1);
        chk("up_words16", wide_t'(u_log.size()), 16);
        chk("up_w8", wide_t'(u_log[8]), 9);
        push_unpack(21);
        repeat (6) step();
        chk("up_w16", wide_t'(u_log[16]), 17);
        chk("up_w23", wide_t'(u_log[23]), 24);
        chk("up_words40", wide_t'(u_log.size()), 40);
        chk("up_order", wide_t'(seq_err(u_log)), 0);

        // Loopback pack -> unpack with random handshakes.
        do_reset();
        loop_mode = 1'b1;
        next_word = 1;
        for (int c = 0; c < 2000; c++) begin
            p_v_d   = 1'($urandom_range(0, 1));
            p_din_d = beat8(next_word);
            gate    = 1'($urandom_range(0, 1));
            u_r_d   = 1'($urandom_range(0, 3) != 0);
            acc_l   = p_v_d && (pq.size() < 20);
            step();
            if (acc_l) next_word += 8;
        end
        p_v_d = 1'b0; gate = 1'b1; u_r_d = 1'b1;
        repeat (20) step();
        chk("loop_order", wide_t'(seq_err(u_log)), 0);
        chk("loop_progress", wide_t'(u_log.size() > 400), 1);
        chk("loop_conserve", wide_t'(u_log.size() + pq.size() + uq.size()), wide_t'(next_word - 1));

        // Reset in the middle of a stream.
        do_reset();
        push_pack(1);
        push_pack(9);
        push_unpack(1);
        u_r_d = 1'b1;
        step();
        u_r_d = 1'b0;
        chk("mid_pre_pvalid", wide_t'(bus.pack_dout_valid), 0);
        chk("mid_pre_uvalid", wide_t'(bus.unpack_dout_valid), 1);
        chk("mid_pre_uw0", wide_t'(bus.unpack_dout[0 +: W]), 9);
`ifdef EIGHT_TWENTY_GEARBOX_FILL_EN
        chk("mid_pre_pfill", wide_t'(pack_fill), 16);
        chk("mid_pre_ufill", wide_t'(unpack_fill), 12);
`endif
        #2 arst = 1'b1;
        #1;
        chk("mid_uvalid", wide_t'(bus.unpack_dout_valid), 0);
        chk("mid_uready", wide_t'(bus.unpack_din_ready), 1);
        chk("mid_pready", wide_t'(bus.pack_din_ready), 1);
        chk("mid_udout",  wide_t'(bus.unpack_dout), 0);
`ifdef EIGHT_TWENTY_GEARBOX_FILL_EN
        chk("mid_pfill", wide_t'(pack_fill), 0);
        chk("mid_ufill", wide_t'(unpack_fill), 0);
`endif
        do_reset();
        run_pack_basic("mid_restart");

`ifdef EIGHT_TWENTY_GEARBOX_FILL_EN
        // Fill count trajectory.
        do_reset();
        p_r_d = 1'b0;
        chk("fill0", wide_t'(pack_fill), 0);
        push_pack(1);
        chk("fill8", wide_t'(pack_fill), 8);
        push_pack(9);
        chk("fill16", wide_t'(pack_fill), 16);
        push_pack(17);
        chk("fill24", wide_t'(pack_fill), 24);
        p_r_d = 1'b1;
        step();
        chk("fill4", wide_t'(pack_fill), 4);
        push_pack(25);
        chk("fill12", wide_t'(pack_fill), 12);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
